load_align_unit: RTL and testbench
==================================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; legal values 32 and 64; BYTES = DATA_W/8.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-005 SHALL have port op  input  3  load type: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU, 111 LD; LD is legal only when DATA_W=64.
REQ-006 SHALL have port addr  input  32  byte address of load, sampled with start.
REQ-007 SHALL have port flush  input  1  abort current load.
REQ-008 SHALL have port bus_req  output  1  memory read request.
REQ-009 SHALL have port bus_addr  output  32  BYTES-aligned read address.
REQ-010 SHALL have port bus_ack  input  1  read-data-valid strobe for the current request.
REQ-011 SHALL have port bus_rdata  input  DATA_W  read data, valid when bus_ack=1.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port rdata  output  DATA_W  extended load result, valid with done, held afterwards.
REQ-015 SHALL have port adel  output  1  address-error or illegal-op flag, valid with done.

Function
REQ-016 SHALL implement FSM states IDLE, REQ0, REQ1, RESP.
REQ-017 SHALL accept start in IDLE only, latching op, addr and offset = addr mod BYTES, then go to REQ0; start outside IDLE is ignored.
REQ-018 SHALL flag an access as misaligned when offset is not a multiple of the access size (1, 2, 4 or 8 bytes).
REQ-019 SHALL flag an access as crossing when offset + size > BYTES.
REQ-020 SHALL, in REQ0, drive bus_req=1 and bus_addr = addr with its low log2(BYTES) bits cleared, both stable until bus_ack.
REQ-021 SHALL, on bus_ack in REQ0, capture lo = bus_rdata, then go to REQ1 if crossing, else to RESP.
REQ-022 SHALL, in REQ1, drive bus_req=1 and bus_addr = (REQ0 address + BYTES) mod 2^32, capture hi on bus_ack, then go to RESP.
REQ-023 SHALL form the result from {hi, lo} shifted right by 8*offset: take the low size bytes, then sign-extend (LB, LH, LW when DATA_W=64) or zero-extend (LBU, LHU, LW when DATA_W=32, LD) to DATA_W.
REQ-024 SHALL, for an illegal op, go from IDLE directly to RESP with adel=1 and issue no bus request.
REQ-025 SHALL, in RESP, pulse done=1 for exactly one cycle, update rdata (except when adel=1), and return to IDLE.
REQ-026 SHALL give latency as follows: start at cycle 0, bus_req from cycle 1, done one cycle after the last bus_ack; minimum 2 cycles non-split, 3 cycles split.
REQ-027 SHALL, on flush in any state, go to IDLE on the next edge, deassert bus_req, suppress done, discard any bus_ack in the same cycle, and hold rdata.
REQ-028 SHALL give flush priority when start and flush are both high in IDLE: the start is dropped.
REQ-029 SHALL hold adel at 0 except during the done pulse of an errored load.

Reset
REQ-030 SHALL, on reset assertion, immediately force state=IDLE, bus_req=0, bus_addr=0, busy=0, done=0, adel=0, rdata=0, lo=hi=0, including mid-transaction.
REQ-031 SHALL ignore bus_ack and start while reset is high.

Configuration
REQ-032 SHALL provide macro MISALIGN_SPLIT_EN.
REQ-033 SHALL, with MISALIGN_SPLIT_EN defined, execute misaligned loads, split into two bus reads when crossing.
REQ-034 SHALL, without MISALIGN_SPLIT_EN, treat any misaligned load as IDLE -> RESP with adel=1 and no bus_req; REQ1 then becomes unreachable.

Verification
REQ-035 SHALL cover: DATA_W=32, LB addr 0x00001003, ack in cycle 1 with bus_rdata 0x80FF0000 -> single bus_addr 0x00001000; rdata 0xFFFFFF80 with done in cycle 2.
REQ-036 SHALL cover: LHU addr 0x00001002, bus_rdata 0xBEEF1234 -> rdata 0x0000BEEF, adel=0.
REQ-037 SHALL cover: with macro, LW addr 0x00001002, reads 0x00001000 -> 0x44332211 and 0x00001004 -> 0x88776655 -> rdata 0x66554433. Without the macro, the same load gives adel=1, done in cycle 1, and no bus_req.
REQ-038 SHALL cover: with macro, LW addr 0xFFFFFFFE -> bus_addr 0xFFFFFFFC, then 0x00000000 (wrap).
REQ-039 SHALL cover: flush asserted in REQ1 in the same cycle as bus_ack -> no done, IDLE next cycle, rdata unchanged; the next LW at 0x0 completes normally.
REQ-040 SHALL cover: DATA_W=64, LD addr 0x8, bus_rdata 0x0123456789ABCDEF -> rdata 0x0123456789ABCDEF. DATA_W=32 with op=111 -> adel=1 and no bus_req.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit
//
// Turns a byte-addressed load (LB/LH/LW/LBU/LHU/LD) into one or two aligned
// bus reads, then shifts and extends the selected bytes into a DATA_W result.
//
// Parameters
//   DATA_W     data bus width in bits, 32 or 64 (BYTES = DATA_W/8)
//
// Build option
//   MISALIGN_SPLIT_EN  when defined, misaligned loads are executed, and loads
//                      that straddle a bus word become two reads. When not
//                      defined, any misaligned load completes at once with
//                      adel=1 and never touches the bus.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   start      load request, only accepted while idle
//   op         load type: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU, 111 LD
//   addr       byte address of the load, sampled with start
//   flush      abort the load in flight
//   bus_req    memory read request
//   bus_addr   BYTES-aligned read address
//   bus_ack    read data valid for the current request
//   bus_rdata  read data
//   busy       high whenever the unit is not idle
//   done       one-cycle completion pulse
//   rdata      extended load result, valid with done and held afterwards
//   adel       address error / illegal op, valid with done

module load_align_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic              flush,
    output logic              bus_req,
    output logic [31:0]       bus_addr,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              adel
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE,
        REQ0,
        REQ1,
        RESP
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [OFFW-1:0]   offset_q;
    logic              split_q;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;

    logic [3:0]        acc_size;
    logic              legal_op;
    logic              misaligned;
    logic              crossing;
    logic              align_err;
    logic              split_req;

    // Decode the incoming request: access size, whether the op exists at
    // this bus width, and how the access sits relative to the bus word.
    always_comb begin
        acc_size = 4'd1;
        legal_op = 1'b1;
        case (op)
            3'b000, 3'b100: acc_size = 4'd1;
            3'b001, 3'b101: acc_size = 4'd2;
            3'b011:         acc_size = 4'd4;
            3'b111: begin
                acc_size = 4'd8;
                legal_op = (DATA_W == 64);
            end
            default:        legal_op = 1'b0;
        endcase
        misaligned = (4'(addr[OFFW-1:0]) & (acc_size - 4'd1)) != 4'd0;
        crossing   = (4'(addr[OFFW-1:0]) + acc_size) > 4'(BYTES);
    end

`ifdef MISALIGN_SPLIT_EN
    assign align_err = 1'b0;
    assign split_req = crossing;
`else
    // A straddling access is always misaligned, so with no split support
    // it is already rejected and the second read never happens.
    assign align_err = misaligned;
    assign split_req = 1'b0;
`endif

    // Shift the two-word window down to the addressed byte, keep the
    // access-size bytes and extend them to the full data width.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [2*DATA_W-1:0] pair,
        input logic [OFFW-1:0]     off,
        input logic [2:0]          o
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        sh = DATA_W'(pair >> {off, 3'b000});
        r  = '0;
        case (o)
            3'b000: r = {{(DATA_W-8){sh[7]}}, sh[7:0]};
            3'b001: r = {{(DATA_W-16){sh[15]}}, sh[15:0]};
            3'b100: r = {{(DATA_W-8){1'b0}}, sh[7:0]};
            3'b101: r = {{(DATA_W-16){1'b0}}, sh[15:0]};
            3'b011: begin
                // LW fills the whole word on a 32-bit bus; on a 64-bit bus
                // the upper half carries its sign.
                r = DATA_W'(sh[31:0]);
                if (DATA_W == 64 && sh[31]) begin
                    r = r | ~DATA_W'(32'hFFFF_FFFF);
                end
            end
            3'b111: r = sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Single state machine with every output registered. done, adel and
    // rdata are set on the edge that enters RESP so they appear together
    // with the RESP cycle; flush overrides everything except reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            offset_q <= '0;
            split_q  <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            bus_req  <= 1'b0;
            bus_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            adel     <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;
            adel <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                bus_req <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op_q     <= op;
                            offset_q <= addr[OFFW-1:0];
                            split_q  <= split_req;
                            busy     <= 1'b1;
                            if (!legal_op || align_err) begin
                                state <= RESP;
                                done  <= 1'b1;
                                adel  <= 1'b1;
                            end else begin
                                state    <= REQ0;
                                bus_req  <= 1'b1;
                                bus_addr <= {addr[31:OFFW], {OFFW{1'b0}}};
                            end
                        end
                    end
                    REQ0: begin
                        if (bus_ack) begin
                            lo <= bus_rdata;
                            if (split_q) begin
                                state    <= REQ1;
                                bus_addr <= bus_addr + 32'(BYTES);
                            end else begin
                                state   <= RESP;
                                bus_req <= 1'b0;
                                done    <= 1'b1;
                                rdata   <= extend_load({hi, bus_rdata}, offset_q, op_q);
                            end
                        end
                    end
                    REQ1: begin
                        if (bus_ack) begin
                            hi      <= bus_rdata;
                            state   <= RESP;
                            bus_req <= 1'b0;
                            done    <= 1'b1;
                            rdata   <= extend_load({bus_rdata, lo}, offset_q, op_q);
                        end
                    end
                    RESP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
//
// Drives a 32-bit and a 64-bit load_align_unit with directed loads. Each
// load pushes its expected completion into a per-instance queue; a monitor
// per instance pops and compares whenever done is seen.

module tb_load_align_unit;

    typedef struct {
        logic [63:0] rdata;
        logic        adel;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start64 = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic        flush = 1'b0;

    logic        busReq, busReq64;
    logic [31:0] busAddr, busAddr64;
    logic        busAck = 1'b0;
    logic        busAck64 = 1'b0;
    logic [31:0] busRdata = 32'h0;
    logic [63:0] busRdata64 = 64'h0;
    logic        busy, busy64, done, done64, adel, adel64;
    logic [31:0] rdata;
    logic [63:0] rdata64;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic [31:0] lastGood = 32'h0;
    exp_t        q32[$];
    exp_t        q64[$];

    load_align_unit u32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .flush(flush),
        .bus_req(busReq), .bus_addr(busAddr), .bus_ack(busAck), .bus_rdata(busRdata),
        .busy(busy), .done(done), .rdata(rdata), .adel(adel)
    );

    load_align_unit #(.DATA_W(64)) u64 (
        .clk(clk), .reset(reset), .start(start64), .op(op), .addr(addr), .flush(flush),
        .bus_req(busReq64), .bus_addr(busAddr64), .bus_ack(busAck64), .bus_rdata(busRdata64),
        .busy(busy64), .done(done64), .rdata(rdata64), .adel(adel64)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Completion monitors: every done must match the oldest queued load.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q32.size() == 0) begin
                checkOutput("unexpected_done32", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                checkOutput({e.name, "_rdata"}, 64'(rdata), e.rdata);
                checkOutput({e.name, "_adel"}, 64'(adel), 64'(e.adel));
                checkOutput({e.name, "_cycle"}, 64'(cycle), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done64) begin
            if (q64.size() == 0) begin
                checkOutput("unexpected_done64", 64'(done64), 64'd0);
            end else begin
                exp_t e;
                e = q64.pop_front();
                checkOutput({e.name, "_rdata"}, rdata64, e.rdata);
                checkOutput({e.name, "_adel"}, 64'(adel64), 64'(e.adel));
                checkOutput({e.name, "_cycle"}, 64'(cycle), 64'(e.cyc));
            end
        end
    end

    // adel must stay low outside a done pulse.
    always @(negedge clk) begin
        if (!reset && !done && adel) checkOutput("adel_outside_done", 64'(adel), 64'd0);
    end

    task automatic waitIdle(input string name);
        for (int i = 0; i < 10; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        checkOutput({name, "_idle_timeout"}, 64'(busy), 64'd0);
    endtask

    // Issue one load on the 32-bit unit, answer its reads at once and queue
    // the expected completion. adel loads expect rdata to hold.
    task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                                 input int nreads, input logic [31:0] ea0, input logic [31:0] d0,
                                 input logic [31:0] ea1, input logic [31:0] d1,
                                 input logic [31:0] er, input logic eadel);
        exp_t e;
        start = 1'b1;
        op = o;
        addr = a;
        if (!eadel) lastGood = er;
        e.rdata = 64'(lastGood);
        e.adel = eadel;
        e.cyc = cycle + nreads + 1;
        e.name = name;
        q32.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        if (nreads == 0) checkOutput({name, "_no_req"}, 64'(busReq), 64'd0);
        for (int i = 0; i < nreads; i++) begin
            checkOutput({name, "_req"}, 64'(busReq), 64'd1);
            checkOutput({name, "_addr"}, 64'(busAddr), 64'(i == 0 ? ea0 : ea1));
            busAck = 1'b1;
            busRdata = (i == 0) ? d0 : d1;
            @(posedge clk); #1;
            busAck = 1'b0;
        end
        waitIdle(name);
    endtask

    task automatic applyStimulus64(input string name, input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] ea, input logic [63:0] d, input logic [63:0] er);
        exp_t e;
        start64 = 1'b1;
        op = o;
        addr = a;
        e.rdata = er;
        e.adel = 1'b0;
        e.cyc = cycle + 2;
        e.name = name;
        q64.push_back(e);
        @(posedge clk); #1;
        start64 = 1'b0;
        checkOutput({name, "_req"}, 64'(busReq64), 64'd1);
        checkOutput({name, "_addr"}, 64'(busAddr64), 64'(ea));
        busAck64 = 1'b1;
        busRdata64 = d;
        @(posedge clk); #1;
        busAck64 = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, "_idle"}, 64'(busy64), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, with start and ack wiggling underneath it.
        busAck = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_req", 64'(busReq), 64'd0);
        checkOutput("rst_addr", 64'(busAddr), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_adel", 64'(adel), 64'd0);
        checkOutput("rst_rdata", 64'(rdata), 64'd0);
        checkOutput("rst_rdata64", rdata64, 64'd0);
        busAck = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus("lb_neg", 3'b000, 32'h0000_1003, 1, 32'h0000_1000, 32'h80FF_0000, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0);
        applyStimulus("lhu", 3'b101, 32'h0000_1002, 1, 32'h0000_1000, 32'hBEEF_1234, 32'h0, 32'h0, 32'h0000_BEEF, 1'b0);
        applyStimulus("lh_neg", 3'b001, 32'h0000_1000, 1, 32'h0000_1000, 32'h0000_8001, 32'h0, 32'h0, 32'hFFFF_8001, 1'b0);
        applyStimulus("lbu", 3'b100, 32'h0000_1001, 1, 32'h0000_1000, 32'h0000_AB00, 32'h0, 32'h0, 32'h0000_00AB, 1'b0);
        applyStimulus("lw", 3'b011, 32'h0000_1004, 1, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        applyStimulus("ld_illegal", 3'b111, 32'h0000_1000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        applyStimulus("op010_illegal", 3'b010, 32'h0000_1000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
`ifdef MISALIGN_SPLIT_EN
        applyStimulus("lw_split", 3'b011, 32'h0000_1002, 2, 32'h0000_1000, 32'h4433_2211, 32'h0000_1004, 32'h8877_6655, 32'h6655_4433, 1'b0);
        applyStimulus("lw_wrap", 3'b011, 32'hFFFF_FFFE, 2, 32'hFFFF_FFFC, 32'hBBAA_0000, 32'h0000_0000, 32'h0000_DDCC, 32'hDDCC_BBAA, 1'b0);
        applyStimulus("lh_mis", 3'b001, 32'h0000_1001, 1, 32'h0000_1000, 32'h0012_3400, 32'h0, 32'h0, 32'h0000_1234, 1'b0);

        // Flush in REQ1 together with the second ack.
        start = 1'b1; op = 3'b011; addr = 32'h0000_1002;
        @(posedge clk); #1;
        start = 1'b0;
        busAck = 1'b1; busRdata = 32'h4433_2211;
        @(posedge clk); #1;
        checkOutput("flush_req1_addr", 64'(busAddr), 64'h0000_1004);
        busRdata = 32'h8877_6655; flush = 1'b1;
`else
        applyStimulus("lw_split_adel", 3'b011, 32'h0000_1002, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        applyStimulus("lw_wrap_adel", 3'b011, 32'hFFFF_FFFE, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        applyStimulus("lh_mis_adel", 3'b001, 32'h0000_1001, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Flush in REQ0 together with the ack.
        start = 1'b1; op = 3'b011; addr = 32'h0000_1008;
        @(posedge clk); #1;
        start = 1'b0;
        busAck = 1'b1; busRdata = 32'h8877_6655; flush = 1'b1;
`endif
        @(posedge clk); #1;
        busAck = 1'b0; flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_req", 64'(busReq), 64'd0);
        checkOutput("flush_rdata", 64'(rdata), 64'(lastGood));
        @(posedge clk); #1;
        checkOutput("flush_still_idle", 64'(busy), 64'd0);
        applyStimulus("lw_after_flush", 3'b011, 32'h0000_0000, 1, 32'h0000_0000, 32'h1357_9BDF, 32'h0, 32'h0, 32'h1357_9BDF, 1'b0);

        // start and flush together in IDLE: the start is dropped.
        start = 1'b1; flush = 1'b1; op = 3'b011; addr = 32'h0000_2000;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checkOutput("startflush_busy", 64'(busy), 64'd0);
        checkOutput("startflush_req", 64'(busReq), 64'd0);

        // Asynchronous reset in the middle of a read.
        start = 1'b1; op = 3'b011; addr = 32'h0000_3004;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("midrst_req_before", 64'(busReq), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_req", 64'(busReq), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_addr", 64'(busAddr), 64'd0);
        checkOutput("midrst_rdata", 64'(rdata), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        lastGood = 32'h0;
        @(posedge clk); #1;
        applyStimulus("lw_after_reset", 3'b011, 32'h0000_3004, 1, 32'h0000_3004, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0);

        // 64-bit unit.
        applyStimulus64("ld64", 3'b111, 32'h0000_0008, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        applyStimulus64("lw64_neg", 3'b011, 32'h0000_0004, 32'h0000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        applyStimulus64("lbu64", 3'b100, 32'h0000_0017, 32'h0000_0010, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("q32_drained", 64'(q32.size()), 64'd0);
        checkOutput("q64_drained", 64'(q64.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
